demux_4_buf: RTL and testbench
==============================

DEMUX_4_BUF -- requirements
Module: demux_4_buf

Interface
REQ-001 SHALL have parameter: N, default 64, data width in bits of the input and each output channel.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: i_in  input  N  data word to distribute.
REQ-005 SHALL have port: i_s  input  2  destination channel select (0..3).
REQ-006 SHALL have port: i_valid  input  1  i_in/i_s valid this cycle.
REQ-007 SHALL have port: o_ready  output  1  block can accept i_in into channel i_s this cycle.
REQ-008 SHALL have ports: o_out0, o_out1, o_out2, o_out3  output  N each  head data of channels 0..3.
REQ-009 SHALL have port: o_valid  output  4  bit k set: o_outk holds valid head data.
REQ-010 SHALL have port: i_ready  input  4  bit k set: consumer of channel k takes o_outk this cycle.
REQ-011 SHALL have port: o_busy  output  1  set when any channel holds at least one entry.

Function
REQ-012 SHALL implement one independent 2-entry FIFO per channel (count 0, 1 or 2), in-order per channel.
REQ-013 SHALL drive o_ready combinationally as 1 when channel i_s count < 2, else 0; o_ready is independent of i_valid and of i_ready.
REQ-014 SHALL accept a write (push) when i_valid && o_ready; i_in is written only to the channel selected by i_s.
REQ-015 SHALL ignore i_in and i_s when i_valid = 0; no state change from the input side.
REQ-016 SHALL pop channel k when o_valid[k] && i_ready[k]; i_ready[k] with o_valid[k] = 0 has no effect.
REQ-017 SHALL set o_valid[k] = 1 exactly when channel k count >= 1; o_outk = oldest entry of channel k.
REQ-018 SHALL have latency 1 cycle: a word pushed at edge t into an empty channel appears on o_outk with o_valid[k] = 1 after edge t.
REQ-019 SHALL, on simultaneous push and pop on the same channel, keep count unchanged, present the next-oldest entry (or the pushed word if count was 1) after the edge, and lose no data.
REQ-020 SHALL allow pops on all four channels and one push in the same cycle, each channel updating independently.
REQ-021 SHALL hold o_outk and o_valid[k] stable while o_valid[k] = 1 and i_ready[k] = 0 (unless count was 1 and a push occurs, which leaves the head unchanged).
REQ-022 SHALL, when channel i_s is full (count 2), deassert o_ready even if i_ready[i_s] = 1 in the same cycle (no pass-through when full).
REQ-023 SHALL hold o_outk at its last value when count of channel k drops to 0; consumers qualify with o_valid[k].
REQ-024 SHALL implement write/read pointers per channel as 1-bit wrapping indices; wrap from 1 to 0 is seamless.
REQ-025 SHALL drive o_busy = OR of o_valid bits.

Reset
REQ-026 SHALL, when i_rst = 1 at a rising edge, clear all channel counts and pointers; after that edge o_valid = 4'b0000, o_busy = 0, o_out0..o_out3 = 0.
REQ-027 SHALL ignore pushes and pops in any cycle where i_rst = 1; data in flight is discarded (reset mid-operation drops contents).
REQ-028 SHALL drive o_ready from channel counts during and after reset (1 for every i_s once counts are 0).

Verification
REQ-029 SHALL cover: reset, then i_valid=1, i_s=2, i_in=0xA5, i_ready=0 for one cycle -> next cycle o_valid=4'b0100, o_out2=0xA5, o_busy=1.
REQ-030 SHALL cover: three pushes to channel 1 (0x1, 0x2, 0x3) with i_ready=0 -> o_ready=0 on third attempt, count stays 2; then i_ready[1]=1 -> o_out1 reads 0x1, then 0x2, then o_valid[1]=0.
REQ-031 SHALL cover: channel 3 holds 0x10 (count 1); same cycle push 0x20 to ch3 and i_ready[3]=1 -> next cycle o_out3=0x20, o_valid[3]=1, count 1.
REQ-032 SHALL cover: one word in each channel (0x0..0x3), i_ready=4'b1111 with push 0x44 to ch0 -> next cycle o_valid=4'b0001, o_out0=0x44.
REQ-033 SHALL cover: channels 0 and 2 full, assert i_rst=1 with i_valid=1 for one cycle -> next cycle o_valid=0, o_busy=0, o_out0..3=0, o_ready=1.
REQ-034 SHALL cover: random push/pop traffic for 10000 cycles on N=64 with scoreboard per channel -> no loss, no duplication, per-channel order preserved.

Source files
------------

// File: rtl/demux_4_buf.sv
// One-to-four demultiplexer with an independent 2-entry FIFO per output channel.
// Each channel keeps a registered head word so o_outk holds its last value once drained.
module demux_4_buf #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_in,
  input  logic [1:0]   i_s,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_out0,
  output logic [N-1:0] o_out1,
  output logic [N-1:0] o_out2,
  output logic [N-1:0] o_out3,
  output logic [3:0]   o_valid,
  input  logic [3:0]   i_ready,
  output logic         o_busy
);

  logic [3:0]   w_full;
  logic [3:0]   w_vld;
  logic [N-1:0] w_head [4];

  assign o_ready = ~w_full[i_s];
  assign o_valid = w_vld;
  assign o_busy  = |w_vld;
  assign o_out0  = w_head[0];
  assign o_out1  = w_head[1];
  assign o_out2  = w_head[2];
  assign o_out3  = w_head[3];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [N-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic [N-1:0] r_head;
    logic         w_push;
    logic         w_pop;
    logic         w_valid;
    logic         w_rp_nxt;
    logic [1:0]   w_cnt_nxt;
    logic [N-1:0] w_head_nxt;

    assign w_valid   = (r_cnt != 2'd0);
    assign w_vld[k]  = w_valid;
    assign w_full[k] = (r_cnt == 2'd2);
    assign w_head[k] = r_head;
    assign w_push    = i_valid && (r_cnt != 2'd2) && (i_s == 2'(k));
    assign w_pop     = w_valid && i_ready[k];

    // Next head is the word at the advanced read pointer, taken straight from
    // i_in when this same edge writes that slot.
    always_comb begin
      w_rp_nxt   = r_rp ^ w_pop;
      w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      w_head_nxt = r_head;
      if (w_cnt_nxt != 2'd0) begin
        if (w_push && (r_wp == w_rp_nxt)) begin
          w_head_nxt = i_in;
        end else begin
          w_head_nxt = r_mem[w_rp_nxt];
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wp     <= 1'b0;
        r_rp     <= 1'b0;
        r_cnt    <= 2'd0;
        r_head   <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wp] <= i_in;
        end
        r_wp   <= r_wp ^ w_push;
        r_rp   <= w_rp_nxt;
        r_cnt  <= w_cnt_nxt;
        r_head <= w_head_nxt;
      end
    end
  end

endmodule

// File: tb/tb_demux_4_buf.sv
// Directed and random bench for demux_4_buf; per-channel queues model the
// expected FIFO contents and a negedge process compares the DUT every cycle.
module tb_demux_4_buf;
  localparam int N = 64;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [N-1:0] i_in;
  logic [1:0]   i_s;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] o_out0, o_out1, o_out2, o_out3;
  logic [3:0]   o_valid;
  logic [3:0]   i_ready;
  logic         o_busy;

  always #5 i_clk = ~i_clk;

  demux_4_buf #(.N(N)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_in   (i_in),
    .i_s    (i_s),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_out0 (o_out0),
    .o_out1 (o_out1),
    .o_out2 (o_out2),
    .o_out3 (o_out3),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_busy (o_busy)
  );

  logic [N-1:0] q [4][$];
  logic [N-1:0] m_out [4];
  bit           cmp_en = 1'b0;
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] dut_out(input int k);
    case (k)
      0: return o_out0;
      1: return o_out1;
      2: return o_out2;
      default: return o_out3;
    endcase
  endfunction

  // Compare process: every negedge once enabled.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), N'(o_valid[k]), N'(q[k].size() > 0));
        chk($sformatf("out%0d", k), dut_out(k), m_out[k]);
      end
      chk("busy", N'(o_busy), N'((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0));
      chk("ready", N'(o_ready), N'(q[i_s].size() < 2));
    end
  end

  // Drive one cycle, advance the model at the edge, return after the compare.
  task automatic step(input logic v, input logic [1:0] s, input logic [N-1:0] d,
                      input logic [3:0] rdy, input logic r);
    bit push;
    i_valid = v; i_s = s; i_in = d; i_ready = rdy; i_rst = r;
    @(posedge i_clk);
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        m_out[k] = '0;
      end
    end else begin
      push = v && (q[s].size() < 2);
      for (int k = 0; k < 4; k++)
        if (rdy[k] && q[k].size() > 0) void'(q[k].pop_front());
      if (push) q[s].push_back(d);
      for (int k = 0; k < 4; k++)
        if (q[k].size() > 0) m_out[k] = q[k][0];
    end
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, '0, 4'b0000, 1'b1);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_s = 2'd0; i_in = '0; i_ready = 4'b0000;
    for (int k = 0; k < 4; k++) m_out[k] = '0;
    do_reset();
    cmp_en = 1'b1;
    do_reset();
    chk("rst_valid", N'(o_valid), N'(4'b0000));
    chk("rst_busy", N'(o_busy), '0);
    chk("rst_out0", o_out0, '0);
    chk("rst_ready", N'(o_ready), N'(1));

    // Single push to channel 2.
    step(1'b1, 2'd2, 64'hA5, 4'b0000, 1'b0);
    chk("p029_valid", N'(o_valid), N'(4'b0100));
    chk("p029_out2", o_out2, 64'hA5);
    chk("p029_busy", N'(o_busy), N'(1));

    // Fill channel 1, third push refused, then drain.
    do_reset();
    step(1'b1, 2'd1, 64'h1, 4'b0000, 1'b0);
    step(1'b1, 2'd1, 64'h2, 4'b0000, 1'b0);
    i_valid = 1'b1; i_s = 2'd1; i_in = 64'h3; i_ready = 4'b0010;
    #1;
    chk("p030_ready_full", N'(o_ready), '0);
    step(1'b1, 2'd1, 64'h3, 4'b0000, 1'b0);
    chk("p030_head1", o_out1, 64'h1);
    step(1'b0, 2'd1, '0, 4'b0010, 1'b0);
    chk("p030_head2", o_out1, 64'h2);
    chk("p030_valid_a", N'(o_valid), N'(4'b0010));
    step(1'b0, 2'd1, '0, 4'b0010, 1'b0);
    chk("p030_valid_b", N'(o_valid), N'(4'b0000));
    chk("p030_hold", o_out1, 64'h2);

    // Simultaneous push and pop at count 1 on channel 3.
    do_reset();
    step(1'b1, 2'd3, 64'h10, 4'b0000, 1'b0);
    step(1'b1, 2'd3, 64'h20, 4'b1000, 1'b0);
    chk("p031_out3", o_out3, 64'h20);
    chk("p031_valid", N'(o_valid), N'(4'b1000));
    step(1'b0, 2'd3, '0, 4'b1000, 1'b0);
    chk("p031_drained", N'(o_valid), N'(4'b0000));

    // Pop all four channels with one push.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), N'(k), 4'b0000, 1'b0);
    chk("p032_pre", N'(o_valid), N'(4'b1111));
    step(1'b1, 2'd0, 64'h44, 4'b1111, 1'b0);
    chk("p032_valid", N'(o_valid), N'(4'b0001));
    chk("p032_out0", o_out0, 64'h44);
    chk("p032_out3_hold", o_out3, 64'h3);

    // Reset with channels 0 and 2 full and a push pending.
    do_reset();
    step(1'b1, 2'd0, 64'hAA, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 64'hBB, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 64'hCC, 4'b0000, 1'b0);
    step(1'b1, 2'd2, 64'hDD, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 64'hEE, 4'b1111, 1'b1);
    chk("p033_valid", N'(o_valid), '0);
    chk("p033_busy", N'(o_busy), '0);
    chk("p033_out0", o_out0, '0);
    chk("p033_out2", o_out2, '0);
    chk("p033_ready", N'(o_ready), N'(1));

    // Random traffic against the queue model.
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'b0);
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
